// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, valid/ready on
// both the operand and the result side. Divide-by-zero completes on the accept edge.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             out_valid_q;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_sub_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // One restoring iteration. The partial remainder needs WIDTH+1 bits only right
  // after the shift; once restored it is below the divisor, so WIDTH bits are kept.
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
    rem_ge_s    = (rem_shift_s >= {1'b0, dsr_q});
    rem_sub_s   = rem_shift_s[WIDTH-1:0] - dsr_q;
    if (rem_ge_s) begin
      rem_d = rem_sub_s;
    end else begin
      rem_d = rem_shift_s[WIDTH-1:0];
    end
    // Quotient bits fill the dividend register from the LSB as its MSBs drain out.
    dvd_d = {dvd_q[WIDTH-2:0], rem_ge_s};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dvd_q       <= {WIDTH{1'b0}};
      dsr_q       <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= {WIDTH{1'b0}};
            cnt_q <= CNT_LAST;
            if (divisor == {WIDTH{1'b0}}) begin
              quotient_q  <= {WIDTH{1'b1}};
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == {CW{1'b0}}) begin
            quotient_q  <= dvd_d;
            remainder_q <= rem_d;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned radix-2 restoring divider. It is the inverse datapath of the team's combinational array multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
- Produces one quotient bit per clock.
- Valid/ready handshakes on both the operand side and the result side. Used to check multiplier results (a*b/b == a) and to evaluate area and latency against the combinational architectures.

Parameters:
- WIDTH, 32, operand width in bits. Dividend, divisor, quotient and remainder are all WIDTH bits wide; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result was produced with divisor == 0

Behaviour:
- Reset (asynchronous, active-low) values:
  - State IDLE; quotient, remainder, div_by_zero, out_valid all 0; iteration counter 0.
  - in_ready = 1 once rst_n is deasserted.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE), combinational from state only.
  - out_valid = (state == DONE), registered.
- IDLE:
  - Operands are accepted on a clock edge where in_valid && in_ready. At that edge (the accept edge), dividend and divisor are captured into internal registers.
  - Partial remainder (WIDTH+1 bits) is cleared to 0 and the counter is set to WIDTH-1.
  - If the captured divisor == 0, go to DONE. Otherwise go to RUN.
- RUN, one iteration per clock edge:
  - Shift the partial remainder left by one and shift in the dividend MSB; the dividend register shifts left.
  - If partial remainder >= divisor: subtract the divisor and shift 1 into the quotient LSB. Otherwise shift in 0.
  - Counter decrements. On the edge where counter == 0, the final iteration completes and the state becomes DONE.
- Latency:
  - Exactly WIDTH clock edges after the accept edge, out_valid is 1. For WIDTH=32, out_valid rises at edge 32.
  - Divide-by-zero: out_valid is 1 after 1 edge.
- DONE:
  - quotient and remainder hold the final values; remainder is the low WIDTH bits of the partial remainder. Its MSB is always 0 here.
  - Outputs hold stable while out_valid && !out_ready.
  - On an edge with out_ready == 1, go to IDLE and drop out_valid. quotient, remainder and div_by_zero keep their last values until the next result.
  - in_ready becomes 1 in the cycle after the result handshake. No operand acceptance overlaps DONE, so throughput is at most one op per WIDTH+2 cycles.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1. For any normal result, div_by_zero = 0.
- in_valid while not IDLE: ignored; operands are not captured and there is no error.
- Input stability: dividend and divisor are sampled only at the accept edge. Later changes have no effect.
- Reset mid-operation (RUN or DONE): immediate abort to IDLE. No out_valid pulse is produced and the in-flight result is lost.
- Arithmetic:
  - Unsigned only.
  - For every non-zero divisor: dividend == quotient*divisor + remainder and remainder < divisor.
  - No intermediate overflow, because the partial remainder has WIDTH+1 bits.
- No X propagation: all state registers are reset.

Test Plan:
- Basic divide: dividend=100, divisor=7, out_ready=1, handshake at edge 0 -> out_valid at edge 32; quotient=14, remainder=2, div_by_zero=0; in_ready returns 1 one cycle after the result handshake.
- Extremes: 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0. 0xFFFFFFFF/0xFFFFFFFF -> q=1, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0.
- Divide by zero: dividend=0x12345678, divisor=0 -> out_valid after 1 edge; q=0xFFFFFFFF, r=0x12345678, div_by_zero=1.
- Backpressure and busy: out_ready=0 for 10 cycles after out_valid -> q/r stay stable with out_valid held. During RUN, in_valid=1 with different operands -> ignored, and the result matches the first operands.
- Reset mid-op: assert rst_n=0 at iteration 15 of 1000/3 -> all outputs return to reset values immediately. After release, 1000/3 -> q=333, r=1 with full 32-edge latency.
- Random regression: 10k random operand pairs (about 1% zero divisors) with random out_ready -> check the q*d+r==dividend and r<d invariants. Also check a*b/b==a using the array multiplier output as the dividend when the product fits in WIDTH bits.
